// File: rtl/fsm_icache_nway_pkg.sv
// Shared definitions for the N-way instruction-cache control FSM:
// state encoding, AXI response codes and parameter-derived widths.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MISS_A = 3'd2,
        ST_MISS   = 3'd3,
        ST_REFILL = 3'd4,
        ST_UNC_A  = 3'd5,
        ST_UNC_R  = 3'd6
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int offs_w_f(input int line_words);
        return $clog2(line_words * 32'sd4);
    endfunction

    function automatic int way_w_f(input int ways);
        return (ways > 32'sd1) ? $clog2(ways) : 32'sd1;
    endfunction

    function automatic int idx_w_f(input int line_words);
        return (line_words > 32'sd1) ? $clog2(line_words) : 32'sd1;
    endfunction

    function automatic logic resp_is_err_f(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY, RESP_EXOKAY: err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/fsm_icache_nway_if.sv
// AXI read address/data channel signals between the cache controller
// (master) and the memory side (slave).
interface fsm_icache_nway_if #(
    parameter int ADDR_W = 32
);
    logic              i_arvalid;
    logic [ADDR_W-1:0] i_araddr;
    logic [7:0]        i_arlen;
    logic              i_arready;
    logic              i_rvalid;
    logic              i_rlast;
    logic [1:0]        i_rresp;
    logic              i_rready;

    modport master (
        output i_arvalid, i_araddr, i_arlen, i_rready,
        input  i_arready, i_rvalid, i_rlast, i_rresp
    );

    modport slave (
        input  i_arvalid, i_araddr, i_arlen, i_rready,
        output i_arready, i_rvalid, i_rlast, i_rresp
    );
endinterface

// File: rtl/fsm_icache_nway_tracker.sv
// Refill beat counter and sticky bus-error flag; a burst whose RLAST does
// not land exactly on the final word is reported as an error.
module axi_beat_tracker
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = idx_w_f(LINE_WORDS)
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             cnt_clr,
    input  logic             err_clr,
    input  logic             beat,
    input  logic             rlast,
    input  logic             resp_err,
    output logic [IDX_W-1:0] cnt,
    output logic             err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             at_last_s;
    logic             err_set_s;

    assign at_last_s = (cnt_q == LAST_IDX);
    assign err_set_s = beat && (resp_err || (rlast != at_last_s));

    // Next beat index (saturating) and error flag.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (beat && !at_last_s) begin
            cnt_d = cnt_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (err_clr) begin
            err_d = 1'b0;
        end else if (err_set_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // The current beat's error is visible immediately so the last beat can decide.
    assign cnt = cnt_q;
    assign err = err_q | err_set_s;

endmodule

// File: rtl/fsm_icache_nway.sv
// Control FSM of an N-way instruction cache: hit lookup, line refill over an
// AXI burst and single-beat uncached fetch. Outputs are decoded from state.
module fsm_icache_nway
    import cache_pkg::*;
#(
    parameter int  WAYS       = 2,
    parameter int  LINE_WORDS = 4,
    parameter int  ADDR_W     = 32,
    localparam int OFFS_W     = offs_w_f(LINE_WORDS),
    localparam int WAY_W      = way_w_f(WAYS),
    localparam int IDX_W      = idx_w_f(LINE_WORDS)
)(
    input  logic               clk,
    input  logic               rstn,
    input  logic               rvalid,
    input  logic               uncached,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [WAYS-1:0]    hit,
    input  logic [WAY_W-1:0]   victim,
    fsm_icache_nway_if.master  axi,
    output logic               rready,
    output logic               rbuf_we,
    output logic               data_sel,
    output logic               fbuf_we,
    output logic [IDX_W-1:0]   fbuf_idx,
    output logic               fbuf_clear,
    output logic [WAYS-1:0]    mem_we,
    output logic [WAYS-1:0]    tagv_we,
    output logic               lru_update,
    output logic               miss_lru_update,
    output logic [WAY_W-1:0]   miss_way,
    output logic               rdata_valid,
    output logic               bus_err
);

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [7:0]        REFILL_LEN = 8'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    logic [WAY_W-1:0]  miss_way_q, miss_way_d;
    logic              trk_beat_s;
    logic              trk_cnt_clr_s;
    logic              trk_err_clr_s;
    logic              trk_err_s;
    logic [IDX_W-1:0]  trk_cnt_s;
    logic              resp_err_s;
    logic [WAYS-1:0]   miss_oh_s;
    logic [ADDR_W-1:0] line_addr_s;
    logic [ADDR_W-1:0] word_addr_s;

    function automatic logic [WAYS-1:0] way_onehot_f(input logic [WAY_W-1:0] way);
        logic [WAYS-1:0] oh;
        oh      = '0;
        oh[way] = 1'b1;
        return oh;
    endfunction

    assign line_addr_s = addr & LINE_MASK;
    assign word_addr_s = addr & WORD_MASK;
    assign resp_err_s  = resp_is_err_f(axi.i_rresp);
    assign miss_oh_s   = way_onehot_f(miss_way_q);

    // Beats only count while a refill burst is in flight; stray R beats elsewhere are ignored.
    assign trk_beat_s    = (state_q == ST_MISS) && axi.i_rvalid;
    assign trk_cnt_clr_s = (state_q == ST_MISS_A) && axi.i_arready;
    assign trk_err_clr_s = ((state_d == ST_MISS_A) && (state_q != ST_MISS_A)) ||
                           ((state_d == ST_UNC_A)  && (state_q != ST_UNC_A));

    axi_beat_tracker #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_tracker (
        .clk      (clk),
        .rstn     (rstn),
        .cnt_clr  (trk_cnt_clr_s),
        .err_clr  (trk_err_clr_s),
        .beat     (trk_beat_s),
        .rlast    (axi.i_rlast),
        .resp_err (resp_err_s),
        .cnt      (trk_cnt_s),
        .err      (trk_err_s)
    );

    // Next-state and output decode.
    always_comb begin
        state_d         = state_q;
        miss_way_d      = miss_way_q;
        rready          = 1'b0;
        rbuf_we         = 1'b0;
        data_sel        = 1'b0;
        fbuf_we         = 1'b0;
        fbuf_idx        = '0;
        fbuf_clear      = 1'b0;
        mem_we          = '0;
        tagv_we         = '0;
        lru_update      = 1'b0;
        miss_lru_update = 1'b0;
        miss_way        = '0;
        rdata_valid     = 1'b0;
        bus_err         = 1'b0;
        axi.i_arvalid   = 1'b0;
        axi.i_araddr    = '0;
        axi.i_arlen     = 8'd0;
        axi.i_rready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rready     = 1'b1;
                rbuf_we    = 1'b1;
                fbuf_clear = 1'b1;
                data_sel   = 1'b1;
                if (rvalid) begin
                    state_d = uncached ? ST_UNC_A : ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (|hit) begin
                    rready     = 1'b1;
                    rbuf_we    = 1'b1;
                    lru_update = 1'b1;
                    fbuf_clear = 1'b1;
                    if (rvalid) begin
                        state_d = uncached ? ST_UNC_A : ST_LOOKUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    miss_way_d = victim;
                    state_d    = ST_MISS_A;
                end
            end
            ST_MISS_A: begin
                axi.i_arvalid = 1'b1;
                axi.i_araddr  = line_addr_s;
                axi.i_arlen   = REFILL_LEN;
                if (axi.i_arready) begin
                    state_d = ST_MISS;
                end else begin
                    state_d = ST_MISS_A;
                end
            end
            ST_MISS: begin
                axi.i_rready = 1'b1;
                fbuf_we      = axi.i_rvalid;
                fbuf_idx     = trk_cnt_s;
                if (axi.i_rvalid && axi.i_rlast) begin
                    if (trk_err_s) begin
                        bus_err = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end else begin
                    state_d = ST_MISS;
                end
            end
            ST_REFILL: begin
                // An errored line never reaches here; the gate is a second line of defence.
                if (!trk_err_s) begin
                    mem_we  = miss_oh_s;
                    tagv_we = miss_oh_s;
                end else begin
                    mem_we  = '0;
                    tagv_we = '0;
                end
                miss_lru_update = 1'b1;
                miss_way        = miss_way_q;
                rdata_valid     = 1'b1;
                state_d         = ST_IDLE;
            end
            ST_UNC_A: begin
                axi.i_arvalid = 1'b1;
                axi.i_araddr  = word_addr_s;
                axi.i_arlen   = 8'd0;
                if (axi.i_arready) begin
                    state_d = ST_UNC_R;
                end else begin
                    state_d = ST_UNC_A;
                end
            end
            ST_UNC_R: begin
                axi.i_rready = 1'b1;
                data_sel     = 1'b1;
                if (axi.i_rvalid) begin
                    rdata_valid = !resp_err_s;
                    bus_err     = resp_err_s;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_UNC_R;
                end
            end
            default: begin
                rready     = 1'b1;
                rbuf_we    = 1'b1;
                fbuf_clear = 1'b1;
                data_sel   = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and refill-way registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            miss_way_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_way_q <= miss_way_d;
        end
    end

endmodule

// File: tb/tb_fsm_icache_nway.sv
// Self-checking bench for fsm_icache_nway: a 2-way/4-word instance for most
// scenarios and a 4-way/8-word instance for the wide refill.
module tb_fsm_icache_nway;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    int total = 0;
    int bad   = 0;

    logic        rvalid, uncached;
    logic [31:0] addr;
    logic [1:0]  hit;
    logic [0:0]  victim;
    logic        rready, rbuf_we, data_sel, fbuf_we, fbuf_clear;
    logic [1:0]  fbuf_idx, mem_we, tagv_we;
    logic        lru_update, miss_lru_update, rdata_valid, bus_err;
    logic [0:0]  miss_way;
    fsm_icache_nway_if #(.ADDR_W(32)) ax ();

    logic        w_rvalid, w_uncached;
    logic [31:0] w_addr;
    logic [3:0]  w_hit;
    logic [1:0]  w_victim;
    logic        w_rready, w_rbuf_we, w_data_sel, w_fbuf_we, w_fbuf_clear;
    logic [2:0]  w_fbuf_idx;
    logic [3:0]  w_mem_we, w_tagv_we;
    logic        w_lru_update, w_miss_lru_update, w_rdata_valid, w_bus_err;
    logic [1:0]  w_miss_way;
    fsm_icache_nway_if #(.ADDR_W(32)) bx ();

    fsm_icache_nway #(.WAYS(2), .LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn), .rvalid(rvalid), .uncached(uncached), .addr(addr),
        .hit(hit), .victim(victim), .axi(ax), .rready(rready), .rbuf_we(rbuf_we),
        .data_sel(data_sel), .fbuf_we(fbuf_we), .fbuf_idx(fbuf_idx), .fbuf_clear(fbuf_clear),
        .mem_we(mem_we), .tagv_we(tagv_we), .lru_update(lru_update),
        .miss_lru_update(miss_lru_update), .miss_way(miss_way),
        .rdata_valid(rdata_valid), .bus_err(bus_err)
    );

    fsm_icache_nway #(.WAYS(4), .LINE_WORDS(8), .ADDR_W(32)) dut_w (
        .clk(clk), .rstn(rstn), .rvalid(w_rvalid), .uncached(w_uncached), .addr(w_addr),
        .hit(w_hit), .victim(w_victim), .axi(bx), .rready(w_rready), .rbuf_we(w_rbuf_we),
        .data_sel(w_data_sel), .fbuf_we(w_fbuf_we), .fbuf_idx(w_fbuf_idx),
        .fbuf_clear(w_fbuf_clear), .mem_we(w_mem_we), .tagv_we(w_tagv_we),
        .lru_update(w_lru_update), .miss_lru_update(w_miss_lru_update),
        .miss_way(w_miss_way), .rdata_valid(w_rdata_valid), .bus_err(w_bus_err)
    );

    // {rready,rbuf_we,fbuf_clear,data_sel,arvalid,rready_axi,fbuf_we,lru,miss_lru,rdata_valid,bus_err,mem_we}
    localparam logic [12:0] IDLE_A   = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [12:0] HIT_A    = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [12:0] QUIET_A  = 13'd0;

    function automatic logic [12:0] ctl_a();
        return {rready, rbuf_we, fbuf_clear, data_sel, ax.i_arvalid, ax.i_rready, fbuf_we,
                lru_update, miss_lru_update, rdata_valid, bus_err, mem_we};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rvalid = 1'b1; uncached = 1'($urandom_range(0, 1)); addr = $urandom; hit = 2'b01;
        ax.i_rvalid = 1'b1; ax.i_rlast = 1'b1; ax.i_arready = 1'b1; ax.i_rresp = 2'b10;
        w_rvalid = 1'b1; bx.i_rvalid = 1'b1; bx.i_arready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (ctl_a() !== IDLE_A) begin
                bad++; $display("FAIL reset_ctl got=%0h exp=%0h", ctl_a(), IDLE_A);
            end
            total++;
            if ({tagv_we, miss_way, w_mem_we, bx.i_arvalid, w_rready} !== {2'b00, 1'b0, 4'b0000, 1'b0, 1'b1}) begin
                bad++; $display("FAIL reset_misc got=%0h exp=1", {tagv_we, miss_way, w_mem_we, bx.i_arvalid, w_rready});
            end
            @(posedge clk);
        end
        rvalid = 1'b0; uncached = 1'b0; hit = 2'b00;
        ax.i_rvalid = 1'b0; ax.i_rlast = 1'b0; ax.i_arready = 1'b0; ax.i_rresp = 2'b00;
        w_rvalid = 1'b0; bx.i_rvalid = 1'b0; bx.i_arready = 1'b0;
        #1 rstn = 1'b1;
        tick();
        total++;
        if (ctl_a() !== IDLE_A) begin
            bad++; $display("FAIL post_reset_idle got=%0h exp=%0h", ctl_a(), IDLE_A);
        end
    endtask

    task automatic test_hits(input int n);
        logic [31:0] ua;
        rvalid = 1'b1; uncached = 1'b0; addr = $urandom; hit = 2'b00;
        tick();
        for (int i = 0; i < n; i++) begin
            hit = 2'b01 << $urandom_range(0, 1); addr = $urandom;
            #1;
            total++;
            if (ctl_a() !== HIT_A) begin
                bad++; $display("FAIL hit_stream_%0d got=%0h exp=%0h", i, ctl_a(), HIT_A);
            end
            tick();
        end
        // Last hit carries an uncached request straight into the AR phase.
        ua = $urandom; uncached = 1'b1; addr = ua;
        tick();
        rvalid = 1'b0; uncached = 1'b0; hit = 2'b00; #1;
        total++;
        if ({ax.i_arvalid, ax.i_araddr, ax.i_arlen} !== {1'b1, ua & 32'hFFFF_FFFC, 8'd0}) begin
            bad++; $display("FAIL hit_to_unc_ar got=%0h exp=%0h", ax.i_araddr, ua & 32'hFFFF_FFFC);
        end
        ax.i_arready = 1'b1; tick(); ax.i_arready = 1'b0;
        ax.i_rvalid = 1'b1; ax.i_rlast = 1'b1; ax.i_rresp = 2'b00; tick();
        ax.i_rvalid = 1'b0; ax.i_rlast = 1'b0;
        // Hit with no follow-on request returns to idle.
        rvalid = 1'b1; tick(); rvalid = 1'b0; hit = 2'b10; tick(); hit = 2'b00; #1;
        total++;
        if (ctl_a() !== IDLE_A) begin
            bad++; $display("FAIL hit_then_idle got=%0h exp=%0h", ctl_a(), IDLE_A);
        end
    endtask

    task automatic run_miss(input logic [31:0] a, input logic v, input int ar_delay,
                            input int nb, input int err_beat, input string tag);
        logic [31:0] exp_line;
        logic        exp_err;
        logic [1:0]  exp_oh;
        int          idx;
        exp_line = a & 32'hFFFF_FFF0;
        exp_err  = (nb != 4) || ((err_beat >= 0) && (err_beat < nb));
        exp_oh   = 2'b01 << v;
        rvalid = 1'b1; uncached = 1'b0; addr = a; hit = 2'b00; victim = v;
        tick();
        rvalid = 1'b0; #1;
        total++;
        if (ctl_a() !== QUIET_A) begin
            bad++; $display("FAIL %s_lookup_miss got=%0h exp=%0h", tag, ctl_a(), QUIET_A);
        end
        tick();
        victim = ~v;
        for (int d = 0; d <= ar_delay; d++) begin
            ax.i_arready = (d == ar_delay); #1;
            total++;
            if ({ax.i_arvalid, ax.i_araddr, ax.i_arlen} !== {1'b1, exp_line, 8'd3}) begin
                bad++; $display("FAIL %s_ar_%0d got=%0b/%0h/%0d exp=1/%0h/3", tag, d,
                                ax.i_arvalid, ax.i_araddr, ax.i_arlen, exp_line);
            end
            tick();
        end
        ax.i_arready = 1'b0;
        for (int k = 0; k < nb; k++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                ax.i_rvalid = 1'b0; #1;
                total++;
                if ({ax.i_rready, fbuf_we, bus_err, mem_we} !== 5'b10000) begin
                    bad++; $display("FAIL %s_gap_%0d got=%0h exp=10", tag, k, {ax.i_rready, fbuf_we, bus_err, mem_we});
                end
                tick();
            end
            ax.i_rvalid = 1'b1; ax.i_rlast = (k == nb - 1);
            ax.i_rresp = (k == err_beat) ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
            idx = (k > 3) ? 3 : k;
            #1;
            total++;
            if ({fbuf_we, fbuf_idx, bus_err} !== {1'b1, 2'(idx), ((k == nb - 1) && exp_err)}) begin
                bad++; $display("FAIL %s_beat_%0d got=%0b/%0d/%0b exp=1/%0d/%0b", tag, k,
                                fbuf_we, fbuf_idx, bus_err, idx, ((k == nb - 1) && exp_err));
            end
            tick();
        end
        ax.i_rvalid = 1'b0; ax.i_rlast = 1'b0; ax.i_rresp = 2'b00; #1;
        if (!exp_err) begin
            total++;
            if ({mem_we, tagv_we, miss_lru_update, rdata_valid, miss_way} !== {exp_oh, exp_oh, 1'b1, 1'b1, v}) begin
                bad++; $display("FAIL %s_refill got=%0h/%0h/%0b/%0b/%0d exp=%0h/%0h/1/1/%0d", tag,
                                mem_we, tagv_we, miss_lru_update, rdata_valid, miss_way, exp_oh, exp_oh, v);
            end
            tick();
        end
        total++;
        if ({ctl_a(), tagv_we} !== {IDLE_A, 2'b00}) begin
            bad++; $display("FAIL %s_end_idle got=%0h exp=%0h", tag, ctl_a(), IDLE_A);
        end
    endtask

    task automatic test_miss_fixed();
        run_miss(32'h1000_0024, 1'b1, 0, 4, -1, "miss_fixed");
    endtask

    task automatic test_bus_error();
        run_miss($urandom, 1'($urandom_range(0, 1)), 1, 4, 2, "bus_err_beat2");
        run_miss($urandom, 1'b0, 0, 3, -1, "short_burst");
        run_miss($urandom, 1'b1, 0, 5, -1, "long_burst");
    endtask

    task automatic test_arready_stall();
        run_miss($urandom, 1'b0, 5, 4, -1, "ar_stall");
    endtask

    task automatic test_miss_random(input int n);
        int nb, eb;
        for (int i = 0; i < n; i++) begin
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 4;
            eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
            run_miss($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), nb, eb, "miss_rand");
        end
    endtask

    task automatic test_uncached(input logic [31:0] a, input int ar_delay, input logic err);
        rvalid = 1'b1; uncached = 1'b1; addr = a;
        tick();
        rvalid = 1'b0; uncached = 1'b0;
        for (int d = 0; d <= ar_delay; d++) begin
            ax.i_arready = (d == ar_delay); #1;
            total++;
            if ({ax.i_arvalid, ax.i_araddr, ax.i_arlen, mem_we} !== {1'b1, a & 32'hFFFF_FFFC, 8'd0, 2'b00}) begin
                bad++; $display("FAIL unc_ar_%0d got=%0b/%0h/%0d exp=1/%0h/0", d,
                                ax.i_arvalid, ax.i_araddr, ax.i_arlen, a & 32'hFFFF_FFFC);
            end
            tick();
        end
        ax.i_arready = 1'b0;
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
            #1;
            total++;
            if ({ax.i_rready, data_sel, rdata_valid, bus_err} !== 4'b1100) begin
                bad++; $display("FAIL unc_wait got=%0b exp=1100", {ax.i_rready, data_sel, rdata_valid, bus_err});
            end
            tick();
        end
        ax.i_rvalid = 1'b1; ax.i_rlast = 1'b1;
        ax.i_rresp = err ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
        #1;
        total++;
        if ({rdata_valid, bus_err, mem_we, tagv_we, lru_update, miss_lru_update} !== {!err, err, 6'd0}) begin
            bad++; $display("FAIL unc_beat got=%0b/%0b/%0h exp=%0b/%0b/0", rdata_valid, bus_err, mem_we, !err, err);
        end
        tick();
        ax.i_rvalid = 1'b0; ax.i_rlast = 1'b0; ax.i_rresp = 2'b00; #1;
        total++;
        if (ctl_a() !== IDLE_A) begin
            bad++; $display("FAIL unc_end_idle got=%0h exp=%0h", ctl_a(), IDLE_A);
        end
    endtask

    task automatic test_stray_beats();
        for (int i = 0; i < 3; i++) begin
            ax.i_rvalid = 1'b1; ax.i_rlast = 1'($urandom_range(0, 1)); ax.i_rresp = 2'($urandom_range(0, 3));
            #1;
            total++;
            if (ctl_a() !== IDLE_A) begin
                bad++; $display("FAIL stray_beat_%0d got=%0h exp=%0h", i, ctl_a(), IDLE_A);
            end
            tick();
        end
        ax.i_rvalid = 1'b0; ax.i_rlast = 1'b0; ax.i_rresp = 2'b00;
        run_miss($urandom, 1'b1, 0, 4, -1, "after_stray");
    endtask

    task automatic test_reset_midburst();
        rvalid = 1'b1; uncached = 1'b0; addr = $urandom; hit = 2'b00; victim = 1'b1;
        tick();
        rvalid = 1'b0; tick();
        ax.i_arready = 1'b1; tick(); ax.i_arready = 1'b0;
        ax.i_rvalid = 1'b1; ax.i_rlast = 1'b0; ax.i_rresp = 2'b00; tick();
        rstn = 1'b0; #1;
        total++;
        if ({ctl_a(), tagv_we} !== {IDLE_A, 2'b00}) begin
            bad++; $display("FAIL midburst_reset got=%0h exp=%0h", ctl_a(), IDLE_A);
        end
        tick();
        rstn = 1'b1;
        for (int k = 2; k < 4; k++) begin
            ax.i_rlast = (k == 3); #1;
            total++;
            if ({ctl_a(), tagv_we} !== {IDLE_A, 2'b00}) begin
                bad++; $display("FAIL residual_beat_%0d got=%0h exp=%0h", k, ctl_a(), IDLE_A);
            end
            tick();
        end
        ax.i_rvalid = 1'b0; ax.i_rlast = 1'b0;
        run_miss($urandom, 1'b0, 0, 4, -1, "after_reset");
    endtask

    task automatic test_wide_refill();
        logic [31:0] a;
        logic [1:0]  v;
        for (int it = 0; it < 2; it++) begin
            a = $urandom;
            v = (it == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            w_rvalid = 1'b1; w_uncached = 1'b0; w_addr = a; w_hit = 4'b0000; w_victim = v;
            tick();
            w_rvalid = 1'b0; tick();
            w_victim = ~v; #1;
            total++;
            if ({bx.i_arvalid, bx.i_araddr, bx.i_arlen} !== {1'b1, a & 32'hFFFF_FFE0, 8'd7}) begin
                bad++; $display("FAIL wide_ar got=%0b/%0h/%0d exp=1/%0h/7", bx.i_arvalid, bx.i_araddr, bx.i_arlen, a & 32'hFFFF_FFE0);
            end
            bx.i_arready = 1'b1; tick(); bx.i_arready = 1'b0;
            for (int k = 0; k < 8; k++) begin
                bx.i_rvalid = 1'b1; bx.i_rlast = (k == 7); bx.i_rresp = 2'b00; #1;
                total++;
                if ({w_fbuf_we, w_fbuf_idx, w_bus_err} !== {1'b1, 3'(k), 1'b0}) begin
                    bad++; $display("FAIL wide_beat_%0d got=%0b/%0d exp=1/%0d", k, w_fbuf_we, w_fbuf_idx, k);
                end
                tick();
            end
            bx.i_rvalid = 1'b0; bx.i_rlast = 1'b0; #1;
            total++;
            if ({w_mem_we, w_tagv_we, w_miss_way, w_rdata_valid} !== {4'b0001 << v, 4'b0001 << v, v, 1'b1}) begin
                bad++; $display("FAIL wide_refill got=%0h/%0h/%0d exp=%0h/%0d", w_mem_we, w_tagv_we, w_miss_way, 4'b0001 << v, v);
            end
            tick();
            total++;
            if ({w_rready, w_mem_we} !== 5'b10000) begin
                bad++; $display("FAIL wide_end_idle got=%0h exp=10", {w_rready, w_mem_we});
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        rvalid = 1'b0; uncached = 1'b0; addr = 32'd0; hit = 2'b00; victim = 1'b0;
        ax.i_arready = 1'b0; ax.i_rvalid = 1'b0; ax.i_rlast = 1'b0; ax.i_rresp = 2'b00;
        w_rvalid = 1'b0; w_uncached = 1'b0; w_addr = 32'd0; w_hit = 4'b0000; w_victim = 2'd0;
        bx.i_arready = 1'b0; bx.i_rvalid = 1'b0; bx.i_rlast = 1'b0; bx.i_rresp = 2'b00;
        #2;
        test_reset();
        test_hits(6);
        test_miss_fixed();
        test_uncached(32'h1FE0_0004, 0, 1'b0);
        test_uncached($urandom, 2, 1'b1);
        test_bus_error();
        test_arready_stall();
        test_stray_beats();
        test_reset_midburst();
        test_miss_random(16);
        test_wide_refill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/fsm_icache_nway.md
FSM_ICACHE_NWAY -- requirements
Module: fsm_icache_nway

Interface
REQ-001 Parameter WAYS, default 2, number of cache ways; SHALL be a power of two, 2..8.
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line; SHALL be a power of two, 1..16; AXI burst length = LINE_WORDS.
REQ-003 Parameter ADDR_W, default 32, address width; derived OFFS_W = log2(LINE_WORDS*4), WAY_W = max(1,log2(WAYS)), IDX_W = max(1,log2(LINE_WORDS)).
REQ-004 One clock and one reset: clk and rstn. Reset is asynchronous and active-low.
REQ-005 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- rvalid  in  1  CPU fetch request
- uncached  in  1  request is uncached; qualified with rvalid
- addr  in  ADDR_W  request address, held stable by the request buffer
- hit  in  WAYS  one-hot tag-compare result
- victim  in  WAY_W  replacement way from LRU
- i_arready / i_rvalid / i_rlast  in  1 each  AXI read handshakes
- i_rresp  in  2  AXI read response
- rready  out  1  can accept a new request
- rbuf_we  out  1  request-buffer load enable
- data_sel  out  1  0 = hit data, 1 = fill/uncached data
- i_arvalid  out  1  AR valid
- i_araddr  out  ADDR_W  AR address
- i_arlen  out  8  AR burst length minus 1
- i_rready  out  1  R ready
- fbuf_we  out  1  fill-buffer beat write
- fbuf_idx  out  IDX_W  fill-buffer word index
- fbuf_clear  out  1  clear the fill buffer
- mem_we  out  WAYS  data-RAM write, one-hot
- tagv_we  out  WAYS  tag/valid write, one-hot
- lru_update  out  1  hit LRU touch
- miss_lru_update  out  1  refill LRU touch
- miss_way  out  WAY_W  way being refilled
- rdata_valid  out  1  uncached/refill data returned
- bus_err  out  1  one-cycle error pulse

Function
REQ-006 States SHALL be IDLE, LOOKUP, MISS_A, MISS, REFILL, UNC_A, UNC_R. Outputs SHALL be combinational from the state and inputs. Every output not listed for a state SHALL be 0.
REQ-007 IDLE: rready=1, rbuf_we=1, fbuf_clear=1, data_sel=1. rvalid&!uncached -> LOOKUP. rvalid&uncached -> UNC_A.
REQ-008 LOOKUP with hit!=0: rready=1, rbuf_we=1, lru_update=1, fbuf_clear=1, data_sel=0. Next state: rvalid&!uncached -> LOOKUP; rvalid&uncached -> UNC_A; otherwise IDLE.
REQ-009 LOOKUP with hit==0: next state MISS_A; victim SHALL be latched into a miss_way register.
REQ-010 MISS_A: i_arvalid=1, i_araddr={addr[ADDR_W-1:OFFS_W],OFFS_W'0}, i_arlen=LINE_WORDS-1. i_arready -> MISS.
REQ-011 MISS: i_rready=1, fbuf_we=i_rvalid, fbuf_idx=beat counter. The beat counter SHALL clear on entry and increment on each i_rvalid. i_rvalid&i_rlast -> REFILL if no error was seen, else IDLE with bus_err=1.
REQ-012 Error flag: set on any beat with i_rresp[1]=1; cleared on entry to MISS_A or UNC_A. An errored line SHALL NOT write mem_we or tagv_we.
REQ-013 i_rlast arriving before or after beat LINE_WORDS-1 SHALL be treated as an error. The beat counter SHALL saturate at LINE_WORDS-1, with no wrap-around.
REQ-014 REFILL: lasts one cycle; mem_we=tagv_we=one-hot(miss_way), miss_lru_update=1, miss_way output valid, rdata_valid=1; next state IDLE.
REQ-015 UNC_A: i_arvalid=1, i_araddr=addr (word-aligned), i_arlen=0. i_arready -> UNC_R.
REQ-016 UNC_R: i_rready=1, data_sel=1. On i_rvalid: rdata_valid=!i_rresp[1] and bus_err=i_rresp[1], then -> IDLE. No cache, tag or LRU write.
REQ-017 i_arvalid SHALL stay asserted with a stable i_araddr until i_arready is seen; i_rvalid outside MISS/UNC_R SHALL be ignored.
REQ-018 The unencoded state value SHALL decode to IDLE outputs and next state IDLE.

Reset
REQ-019 While rstn=0: state=IDLE, beat counter=0, error flag=0, miss_way=0. Outputs SHALL equal the IDLE values of REQ-007.
REQ-020 Reset mid-burst SHALL abandon the transaction with no RAM write. Any residual R beats SHALL be ignored per REQ-017.

Structure
REQ-021 State encoding, the AXI RESP constants and the OFFS_W/IDX_W/WAY_W helper functions SHALL live in the shared package cache_pkg.
REQ-022 The beat counter and error flag SHALL form one sub-module, axi_beat_tracker.

Verification
REQ-023 WAYS=2, LINE_WORDS=4. Hit on consecutive requests: LOOKUP holds, lru_update=1 each cycle, rready never drops.
REQ-024 Miss at addr 0x1000_0024 with victim=1: i_araddr=0x1000_0020, i_arlen=3; fbuf_idx 0..3 on four beats; REFILL gives mem_we=tagv_we=2'b10, then IDLE.
REQ-025 Uncached read at 0x1FE0_0004: i_arlen=0, one beat, rdata_valid=1, mem_we stays 0.
REQ-026 i_rresp=2'b10 on beat 2 of 4: bus_err pulses after the last beat, no REFILL, next state IDLE.
REQ-027 i_arready held low for 5 cycles: i_arvalid and i_araddr stay stable. rstn low during beat 1: state IDLE with all write enables 0.
REQ-028 WAYS=4, LINE_WORDS=8: victim=3 refill gives mem_we=4'b1000 and i_arlen=7.
